gb_pixel_capture: RTL and testbench



---
 rtl/gb_video_pkg.sv | 23 ++
 rtl/gb_pixel_capture_if.sv | 12 +
 rtl/sync_fifo.sv | 43 ++++
 rtl/gb_pixel_capture.sv | 172 +++++++++++++++++
 tb/tb_gb_pixel_capture.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gb_video_pkg.sv
// rtl/gb_video_pkg.sv - gameboy LCD geometry, capture states and pixel packing helper
package gb_video_pkg;
  localparam int GB_WIDTH          = 160;
  localparam int GB_HEIGHT         = 144;
  localparam int GB_BYTES_PER_LINE = 40;
  localparam int FB_ADDR_W         = 13;

  typedef enum logic [1:0] {
    WAIT_FRAME,
    CAPTURE,
    DONE
  } capture_state_t;

  // Left-justify 1-3 pending pixels (oldest in the MSBs) and zero-fill the rest of the byte.
  function automatic logic [7:0] pad_pixels(input logic [5:0] pending, input logic [1:0] count);
    case (count)
      2'd1:    pad_pixels = {pending[1:0], 6'b0};
      2'd2:    pad_pixels = {pending[3:0], 4'b0};
      2'd3:    pad_pixels = {pending[5:0], 2'b0};
      default: pad_pixels = 8'h00;
    endcase
  endfunction
endpackage

// File: rtl/gb_pixel_capture_if.sv
// rtl/gb_pixel_capture_if.sv - framebuffer RAM write port
interface gb_pixel_capture_if;
  import gb_video_pkg::*;

  logic [FB_ADDR_W-1:0] fb_addr;
  logic [7:0]           fb_data;
  logic                 fb_we;
  logic                 fb_ready;

  modport master (output fb_addr, output fb_data, output fb_we, input fb_ready);
  modport slave  (input fb_addr, input fb_data, input fb_we, output fb_ready);
endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with head-of-queue data output
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head_data
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_pop;
  logic             do_push;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop    = pop && !empty;
  // A push into a full FIFO still lands when the head leaves on the same cycle.
  assign do_push   = push && (!full || do_pop);
  assign head_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/gb_pixel_capture.sv
// rtl/gb_pixel_capture.sv - packs gameboy LCD pixels four-per-byte into the framebuffer
module gb_pixel_capture
  import gb_video_pkg::*;
#(
  parameter int WIDTH      = GB_WIDTH,
  parameter int HEIGHT     = GB_HEIGHT,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [1:0]         pixel_data,
  input  logic               pixel_clock,
  input  logic               pixel_latch,
  input  logic               hsync,
  input  logic               vsync,
  gb_pixel_capture_if.master fb,
  output logic               frame_done,
  output logic [7:0]         line_count,
  output logic               overflow
);
  localparam int                   ENTRY_W    = 8 + FB_ADDR_W;
  localparam logic [7:0]           X_LIMIT    = 8'(WIDTH);
  localparam logic [7:0]           LAST_LINE  = 8'(HEIGHT - 1);
  localparam logic [FB_ADDR_W-1:0] LINE_BYTES = FB_ADDR_W'(WIDTH / 4);

  logic [1:0]           pix_q;
  logic                 latch_q, pclk_q, pclk_d, hsync_q, hsync_d, vsync_q, vsync_d;
  logic                 pclk_rise, hsync_rise, vsync_rise;
  capture_state_t       state_q, state_d;
  logic                 pixel_act, hsync_act;
  logic [7:0]           x_q, x_d, x_px;
  logic [5:0]           pack_q, pack_d, pack_px;
  logic [FB_ADDR_W-1:0] line_base_q, line_base_d;
  logic [7:0]           line_count_q, line_count_d;
  logic                 frame_done_q, frame_done_d;
  logic                 push_valid_q, push_valid_d;
  logic [ENTRY_W-1:0]   push_entry_q, push_entry_d;
  logic                 overflow_q;
  logic                 fifo_full, fifo_empty, fifo_pop;
  logic [ENTRY_W-1:0]   fifo_head;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pix_q   <= '0;
      latch_q <= 1'b0;
      pclk_q  <= 1'b0;
      pclk_d  <= 1'b0;
      hsync_q <= 1'b0;
      hsync_d <= 1'b0;
      vsync_q <= 1'b0;
      vsync_d <= 1'b0;
    end else begin
      pix_q   <= pixel_data;
      latch_q <= pixel_latch;
      pclk_q  <= pixel_clock;
      pclk_d  <= pclk_q;
      hsync_q <= hsync;
      hsync_d <= hsync_q;
      vsync_q <= vsync;
      vsync_d <= vsync_q;
    end
  end

  assign pclk_rise  = pclk_q & ~pclk_d;
  assign hsync_rise = hsync_q & ~hsync_d;
  assign vsync_rise = vsync_q & ~vsync_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= WAIT_FRAME;
    else          state_q <= state_d;
  end

  // Priority is vsync, then hsync, then pixel; only CAPTURE looks at pixels and hsync.
  always_comb begin
    state_d   = state_q;
    pixel_act = 1'b0;
    hsync_act = 1'b0;
    if (vsync_rise) begin
      state_d = CAPTURE;
    end else if (state_q == CAPTURE) begin
      pixel_act = pclk_rise && latch_q && (x_q < X_LIMIT);
      hsync_act = hsync_rise;
      if (hsync_rise && (line_count_q == LAST_LINE)) state_d = DONE;
    end
  end

  always_comb begin
    x_px         = x_q;
    pack_px      = pack_q;
    x_d          = x_q;
    pack_d       = pack_q;
    line_base_d  = line_base_q;
    line_count_d = line_count_q;
    frame_done_d = 1'b0;
    push_valid_d = 1'b0;
    push_entry_d = '0;
    if (vsync_rise) begin
      x_d          = '0;
      pack_d       = '0;
      line_base_d  = '0;
      line_count_d = '0;
      frame_done_d = (line_count_q != 8'd0);
    end else begin
      if (pixel_act) begin
        x_px = x_q + 8'd1;
        if (x_q[1:0] == 2'd3) begin
          push_valid_d = 1'b1;
          push_entry_d = {pack_q, pix_q, line_base_q + FB_ADDR_W'(x_q[7:2])};
          pack_px      = '0;
        end else begin
          pack_px = {pack_q[3:0], pix_q};
        end
      end
      x_d    = x_px;
      pack_d = pack_px;
      // A byte completed by a coincident pixel leaves x_px[1:0]==0, so at most one push per cycle.
      if (hsync_act) begin
        if (x_px[1:0] != 2'd0) begin
          push_valid_d = 1'b1;
          push_entry_d = {pad_pixels(pack_px, x_px[1:0]), line_base_q + FB_ADDR_W'(x_px[7:2])};
        end
        x_d          = '0;
        pack_d       = '0;
        line_base_d  = line_base_q + LINE_BYTES;
        line_count_d = line_count_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      x_q          <= '0;
      pack_q       <= '0;
      line_base_q  <= '0;
      line_count_q <= '0;
      frame_done_q <= 1'b0;
      push_valid_q <= 1'b0;
      push_entry_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      x_q          <= x_d;
      pack_q       <= pack_d;
      line_base_q  <= line_base_d;
      line_count_q <= line_count_d;
      frame_done_q <= frame_done_d;
      push_valid_q <= push_valid_d;
      push_entry_q <= push_entry_d;
      if (push_valid_q && fifo_full && !fifo_pop) overflow_q <= 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (push_valid_q),
    .push_data (push_entry_q),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head_data (fifo_head)
  );

  assign fifo_pop                = fb.fb_we & fb.fb_ready;
  assign fb.fb_we                = ~fifo_empty;
  assign {fb.fb_data, fb.fb_addr} = fifo_head;
  assign frame_done              = frame_done_q;
  assign line_count              = line_count_q;
  assign overflow                = overflow_q;
endmodule

// File: tb/tb_gb_pixel_capture.sv
// tb/tb_gb_pixel_capture.sv - scoreboard bench for gb_pixel_capture
module tb_gb_pixel_capture;
  import gb_video_pkg::*;

  logic       clock;
  logic       reset_n;
  logic [1:0] pixel_data;
  logic       pixel_clock;
  logic       pixel_latch;
  logic       hsync;
  logic       vsync;
  logic       frame_done;
  logic [7:0] line_count;
  logic       overflow;

  gb_pixel_capture_if fb ();

  gb_pixel_capture dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .pixel_data  (pixel_data),
    .pixel_clock (pixel_clock),
    .pixel_latch (pixel_latch),
    .hsync       (hsync),
    .vsync       (vsync),
    .fb          (fb),
    .frame_done  (frame_done),
    .line_count  (line_count),
    .overflow    (overflow)
  );

  int checks = 0;
  int errors = 0;
  int writes = 0;
  int frame_done_cnt = 0;
  int last_addr = -1;
  logic [20:0] exp_q [$];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected entries are {data, addr}; every accepted write pops one.
  always begin
    logic [20:0] e;
    @(negedge clock);
    #2;
    if (fb.fb_we === 1'b1 && fb.fb_ready === 1'b1) begin
      writes++;
      last_addr = int'(fb.fb_addr);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr %0d data %02h, expected no write", fb.fb_addr, fb.fb_data);
      end else begin
        e = exp_q.pop_front();
        if ({fb.fb_data, fb.fb_addr} !== e)
        begin
          errors++;
          $display("FAIL fb_write: got addr %0d data %02h, expected addr %0d data %02h",
                   fb.fb_addr, fb.fb_data, e[12:0], e[20:13]);
        end
      end
    end
    if (frame_done === 1'b1) frame_done_cnt++;
  end

  task automatic do_reset();
    @(negedge clock);
    reset_n     = 1'b0;
    pixel_data  = 2'b00;
    pixel_clock = 1'b0;
    pixel_latch = 1'b0;
    hsync       = 1'b0;
    vsync       = 1'b0;
    fb.fb_ready = 1'b1;
    repeat (2) @(negedge clock);
    exp_q.delete();
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic drive_pixel(input logic [1:0] v, input logic latch);
    @(negedge clock);
    pixel_data  = v;
    pixel_latch = latch;
    pixel_clock = 1'b1;
    @(negedge clock);
    pixel_clock = 1'b0;
  endtask

  task automatic pulse_hsync();
    @(negedge clock); hsync = 1'b1;
    @(negedge clock); hsync = 1'b0;
    repeat (3) @(negedge clock);
  endtask

  task automatic pulse_vsync();
    @(negedge clock); vsync = 1'b1;
    @(negedge clock); vsync = 1'b0;
    repeat (3) @(negedge clock);
  endtask

  // mode 0: i%4, mode 1: all 3, else random; noise inserts an unlatched pixel before each one.
  task automatic send_line(input int npix, input int line, input int mode, input bit noise, input int max_exp);
    logic [1:0] px [0:199];
    logic [7:0] b;
    int nacc;
    for (int i = 0; i < npix; i++) begin
      case (mode)
        0:       px[i] = 2'(i % 4);
        1:       px[i] = 2'b11;
        default: px[i] = 2'($urandom_range(3, 0));
      endcase
    end
    nacc = (npix < GB_WIDTH) ? npix : GB_WIDTH;
    for (int g = 0; g * 4 < nacc; g++) begin
      b = 8'h00;
      for (int k = 0; k < 4; k++)
        if (g * 4 + k < nacc) b[7 - 2 * k -: 2] = px[g * 4 + k];
      if (g < max_exp) exp_q.push_back({b, 13'(line * GB_BYTES_PER_LINE + g)});
    end
    for (int i = 0; i < npix; i++) begin
      if (noise) drive_pixel(2'b10, 1'b0);
      drive_pixel(px[i], 1'b1);
    end
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d expected writes still outstanding, required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    int w0;
    do_reset();
    checks += 7;
    if (fb.fb_we !== 1'b0) begin errors++; $display("FAIL reset_fb_we: got %b, expected 0", fb.fb_we); end
    if (fb.fb_addr !== 13'd0) begin errors++; $display("FAIL reset_fb_addr: got %0d, expected 0", fb.fb_addr); end
    if (fb.fb_data !== 8'd0) begin errors++; $display("FAIL reset_fb_data: got %02h, expected 00", fb.fb_data); end
    if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b, expected 0", frame_done); end
    if (line_count !== 8'd0) begin errors++; $display("FAIL reset_line_count: got %0d, expected 0", line_count); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b, expected 0", overflow); end
    if (dut.state_q !== WAIT_FRAME) begin errors++; $display("FAIL reset_state: got %0d, expected %0d", dut.state_q, WAIT_FRAME); end
    w0 = writes;
    for (int i = 0; i < 8; i++) drive_pixel(2'(i), 1'b1);
    pulse_hsync();
    repeat (5) @(negedge clock);
    checks += 2;
    if (writes - w0 != 0) begin errors++; $display("FAIL wait_frame_writes: got %0d, expected 0", writes - w0); end
    if (line_count !== 8'd0) begin errors++; $display("FAIL wait_frame_line_count: got %0d, expected 0", line_count); end
  endtask

  task automatic test_latency();
    do_reset();
    pulse_vsync();
    for (int i = 0; i < 3; i++) drive_pixel(2'(i), 1'b1);
    exp_q.push_back({8'h1B, 13'd0});
    @(negedge clock);
    pixel_data = 2'd3; pixel_latch = 1'b1; pixel_clock = 1'b1;
    @(negedge clock);
    pixel_clock = 1'b0;
    @(negedge clock);
    checks++;
    if (fb.fb_we !== 1'b0) begin errors++; $display("FAIL latency_early: fb_we %b after 2 clocks, expected 0", fb.fb_we); end
    @(negedge clock);
    checks++;
    if (fb.fb_we !== 1'b1) begin errors++; $display("FAIL latency_3clk: fb_we %b after 3 clocks, expected 1", fb.fb_we); end
    wait_drain("latency");
  endtask

  task automatic test_single_line();
    int w0, f0;
    do_reset();
    w0 = writes; f0 = frame_done_cnt;
    pulse_vsync();
    send_line(160, 0, 0, 1'b0, 1000);
    pulse_hsync();
    wait_drain("single_line");
    checks += 3;
    if (writes - w0 != 40) begin errors++; $display("FAIL single_line_writes: got %0d, expected 40", writes - w0); end
    if (line_count !== 8'd1) begin errors++; $display("FAIL single_line_count: got %0d, expected 1", line_count); end
    if (frame_done_cnt != f0) begin errors++; $display("FAIL first_vsync_frame_done: got %0d pulses, expected 0", frame_done_cnt - f0); end
  endtask

  task automatic test_partial_line();
    int w0;
    do_reset();
    w0 = writes;
    pulse_vsync();
    send_line(6, 0, 1, 1'b0, 1000);
    pulse_hsync();
    send_line(4, 1, 0, 1'b0, 1000);
    pulse_hsync();
    wait_drain("partial_line");
    checks += 2;
    if (writes - w0 != 3) begin errors++; $display("FAIL partial_writes: got %0d, expected 3", writes - w0); end
    if (line_count !== 8'd2) begin errors++; $display("FAIL partial_line_count: got %0d, expected 2", line_count); end
  endtask

  task automatic test_overflow();
    int w0;
    do_reset();
    w0 = writes;
    pulse_vsync();
    fb.fb_ready = 1'b0;
    send_line(16, 0, 2, 1'b0, 4);
    repeat (4) @(negedge clock);
    checks += 2;
    if (overflow !== 1'b0) begin errors++; $display("FAIL overflow_early: got %b, expected 0", overflow); end
    if (fb.fb_we !== 1'b1) begin errors++; $display("FAIL overflow_we_held: got %b, expected 1", fb.fb_we); end
    send_line(4, 0, 2, 1'b0, 0);
    repeat (4) @(negedge clock);
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_set: got %b, expected 1", overflow); end
    fb.fb_ready = 1'b1;
    wait_drain("overflow");
    repeat (5) @(negedge clock);
    checks += 2;
    if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_sticky: got %b, expected 1", overflow); end
    if (writes - w0 != 4) begin errors++; $display("FAIL overflow_writes: got %0d, expected 4", writes - w0); end
    do_reset();
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL overflow_reset: got %b, expected 0", overflow); end
  endtask

  task automatic test_latch_long_line();
    int w0;
    do_reset();
    w0 = writes;
    pulse_vsync();
    send_line(170, 0, 0, 1'b1, 1000);
    pulse_hsync();
    wait_drain("long_line");
    checks += 2;
    if (writes - w0 != 40) begin errors++; $display("FAIL long_line_writes: got %0d, expected 40", writes - w0); end
    if (line_count !== 8'd1) begin errors++; $display("FAIL long_line_count: got %0d, expected 1", line_count); end
  endtask

  task automatic test_full_frame();
    int w0, f0;
    do_reset();
    pulse_vsync();
    w0 = writes; f0 = frame_done_cnt;
    for (int l = 0; l < GB_HEIGHT; l++) begin
      send_line(160, l, 2, 1'b0, 1000);
      pulse_hsync();
    end
    repeat (4) @(negedge clock);
    checks += 3;
    if (dut.state_q !== DONE) begin errors++; $display("FAIL frame_state_done: got %0d, expected %0d", dut.state_q, DONE); end
    if (line_count !== 8'd144) begin errors++; $display("FAIL frame_line_count: got %0d, expected 144", line_count); end
    if (frame_done_cnt != f0) begin errors++; $display("FAIL frame_done_early: got %0d pulses, expected 0", frame_done_cnt - f0); end
    for (int i = 0; i < 8; i++) drive_pixel(2'b11, 1'b1);
    pulse_hsync();
    pulse_vsync();
    wait_drain("frame");
    repeat (4) @(negedge clock);
    checks += 5;
    if (frame_done_cnt - f0 != 1) begin errors++; $display("FAIL frame_done_count: got %0d pulses, expected 1", frame_done_cnt - f0); end
    if (writes - w0 != 5760) begin errors++; $display("FAIL frame_writes: got %0d, expected 5760", writes - w0); end
    if (last_addr != 5759) begin errors++; $display("FAIL frame_last_addr: got %0d, expected 5759", last_addr); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL frame_overflow: got %b, expected 0", overflow); end
    if (line_count !== 8'd0) begin errors++; $display("FAIL frame_vsync_clear: got %0d, expected 0", line_count); end
  endtask

  task automatic test_reset_mid_line();
    int w0;
    do_reset();
    pulse_vsync();
    fb.fb_ready = 1'b0;
    for (int i = 0; i < 8; i++) drive_pixel(2'(i), 1'b1);
    repeat (4) @(negedge clock);
    checks++;
    if (fb.fb_we !== 1'b1) begin errors++; $display("FAIL midreset_pending: got fb_we %b, expected 1", fb.fb_we); end
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    checks++;
    if (fb.fb_we !== 1'b0) begin errors++; $display("FAIL midreset_async_we: got %b, expected 0", fb.fb_we); end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    fb.fb_ready = 1'b1;
    w0 = writes;
    for (int i = 0; i < 12; i++) drive_pixel(2'(i), 1'b1);
    pulse_hsync();
    repeat (10) @(negedge clock);
    checks += 3;
    if (writes - w0 != 0) begin errors++; $display("FAIL midreset_writes: got %0d, expected 0", writes - w0); end
    if (line_count !== 8'd0) begin errors++; $display("FAIL midreset_line_count: got %0d, expected 0", line_count); end
    if (dut.state_q !== WAIT_FRAME) begin errors++; $display("FAIL midreset_state: got %0d, expected %0d", dut.state_q, WAIT_FRAME); end
  endtask

  initial begin
    reset_n     = 1'b0;
    pixel_data  = 2'b00;
    pixel_clock = 1'b0;
    pixel_latch = 1'b0;
    hsync       = 1'b0;
    vsync       = 1'b0;
    fb.fb_ready = 1'b1;
    test_reset();
    test_latency();
    test_single_line();
    test_partial_line();
    test_overflow();
    test_latch_long_line();
    test_full_frame();
    test_reset_mid_line();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
